// File: rtl/song_sample_player.sv
// Song RAM sample player: fetches a 6-bit sample per tick and formats it as a signed 32-bit word.
// The word is queued in a small FIFO and drained to the audio controller whenever it accepts data.
module song_sample_player #(
    parameter int DIV        = 1042,
    parameter int LAST_ADDR  = 633867,
    parameter int SHIFT      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    output logic [19:0] ram_addr,
    input  logic [5:0]  ram_q,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        song_done,
    output logic        dropped
);

    localparam int CW = $clog2(DIV);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [19:0]     addr_q, addr_d;
    logic            done_q, done_d;
    logic            dropped_q, dropped_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [31:0]     fifo_mem [FIFO_DEPTH];

    logic            tick_s;
    logic            empty_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic [31:0]     push_data_s;
    logic [31:0]     head_s;

    // Centre the unsigned sample around 32 and scale it into the top bits.
    function automatic logic [31:0] fmt_sample(input logic [5:0] q);
        return ({26'd0, q} - 32'd32) << SHIFT;
    endfunction

    assign tick_s   = (cnt_q == CW'(DIV - 1));
    assign empty_s  = (count_q == '0);
    assign full_s   = (count_q == (PW + 1)'(FIFO_DEPTH));
    assign head_s   = fifo_mem[rd_ptr_q];

    assign ram_addr                = addr_q;
    assign song_done               = done_q;
    assign dropped                 = dropped_q;
    assign write_audio_out         = !empty_s && audio_out_allowed;
    assign left_channel_audio_out  = empty_s ? 32'd0 : head_s;
    assign right_channel_audio_out = empty_s ? 32'd0 : head_s;

    // Next-state logic: tick counter, fetch FSM, address, FIFO pointers; restart overrides all but the tick counter.
    always_comb begin
        cnt_d       = tick_s ? '0 : cnt_q + CW'(1);
        state_d     = state_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        dropped_d   = dropped_q;
        push_s      = 1'b0;
        push_data_s = 32'd0;
        pop_s       = !empty_s && audio_out_allowed;

        case (state_q)
            S_IDLE: begin
                if (tick_s) begin
                    if (full_s) begin
                        dropped_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d = S_IDLE;
                push_s  = 1'b1;
                if (enable) begin
                    push_data_s = fmt_sample(ram_q);
                    if (addr_q == 20'(LAST_ADDR)) begin
                        addr_d = 20'd0;
                        done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 20'd1;
                    end
                end else begin
                    push_data_s = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (restart) begin
            state_d   = S_IDLE;
            addr_d    = 20'd0;
            done_d    = 1'b0;
            dropped_d = 1'b0;
            push_s    = 1'b0;
            pop_s     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            dropped_d = dropped_d;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            addr_q    <= 20'd0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage needs no reset: unread entries are masked by the empty flag.
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= push_data_s;
        end
    end

endmodule

// File: tb/tb_song_sample_player.sv
// Randomized bench for song_sample_player, checked every cycle against a queue-based reference model.
module tb_song_sample_player;

    localparam int P_DIV   = 8;
    localparam int P_LAST  = 5;
    localparam int P_SHIFT = 24;
    localparam int P_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        restart = 1'b0;
    logic        allowed = 1'b1;
    logic [19:0] ram_addr;
    logic [5:0]  ram_q = 6'd0;
    logic        write_audio_out;
    logic [31:0] left_out, right_out;
    logic        song_done, dropped;

    logic        use_fixed = 1'b1;
    logic [5:0]  fixed_val = 6'd63;
    logic [5:0]  mem [8];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model state
    int          m_cnt;
    int          m_stage;   // 0 idle, 1 address presented, 2 data capture
    logic [19:0] m_addr;
    logic [31:0] m_fifo[$];
    logic        m_dropped;
    logic        m_done;

    song_sample_player #(
        .DIV(P_DIV), .LAST_ADDR(P_LAST), .SHIFT(P_SHIFT), .FIFO_DEPTH(P_DEPTH)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .enable(enable),
        .restart(restart),
        .ram_addr(ram_addr),
        .ram_q(ram_q),
        .audio_out_allowed(allowed),
        .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_out),
        .right_channel_audio_out(right_out),
        .song_done(song_done),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Registered song RAM with one cycle of read latency.
    always @(posedge clk) begin
        ram_q <= use_fixed ? fixed_val : mem[ram_addr[2:0]];
    end

    function automatic logic [5:0] ram_val(input logic [19:0] a);
        return use_fixed ? fixed_val : mem[a[2:0]];
    endfunction

    function automatic logic [31:0] model_fmt(input logic [5:0] q);
        longint v;
        v = (longint'(q) - 64'sd32) * (64'sd1 <<< P_SHIFT);
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_stage = 0;
        m_addr = 20'd0;
        m_fifo.delete();
        m_dropped = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        bit tick, full, pop;
        tick = (m_cnt == P_DIV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (restart) begin
            m_addr = 20'd0;
            m_fifo.delete();
            m_stage = 0;
            m_dropped = 1'b0;
            m_done = 1'b0;
        end else begin
            full = (m_fifo.size() == P_DEPTH);
            pop  = (m_fifo.size() > 0) && allowed;
            m_done = 1'b0;
            if (pop) void'(m_fifo.pop_front());
            if (m_stage == 2) begin
                if (enable) begin
                    m_fifo.push_back(model_fmt(ram_val(m_addr)));
                    if (m_addr == 20'(P_LAST)) begin
                        m_addr = 20'd0;
                        m_done = 1'b1;
                    end else begin
                        m_addr = m_addr + 20'd1;
                    end
                end else begin
                    m_fifo.push_back(32'd0);
                end
                m_stage = 0;
            end else if (m_stage == 1) begin
                m_stage = 2;
            end else if (tick) begin
                if (full) m_dropped = 1'b1;
                else      m_stage = 1;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] exp_d;
        exp_d = (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
        chk("ram_addr", {12'd0, ram_addr}, {12'd0, m_addr});
        chk("write", {31'd0, write_audio_out}, {31'd0, (m_fifo.size() > 0) && allowed});
        chk("left", left_out, exp_d);
        chk("right", right_out, exp_d);
        chk("song_done", {31'd0, song_done}, {31'd0, m_done});
        chk("dropped", {31'd0, dropped}, {31'd0, m_dropped});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_write"}, {31'd0, write_audio_out}, 32'd0);
        chk({tag, "_left"}, left_out, 32'd0);
        chk({tag, "_right"}, right_out, 32'd0);
        chk({tag, "_addr"}, {12'd0, ram_addr}, 32'd0);
        chk({tag, "_done"}, {31'd0, song_done}, 32'd0);
        chk({tag, "_dropped"}, {31'd0, dropped}, 32'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        restart = 1'b0;
        model_reset();
    endtask

    initial begin
        int first_write;
        logic [31:0] first_data;
        logic [19:0] held_addr;
        int waited;

        foreach (mem[i]) mem[i] = 6'($urandom_range(0, 63));

        // Pin the model's formatting to hand-computed values.
        chk("fmt_0", model_fmt(6'd0), 32'hE000_0000);
        chk("fmt_32", model_fmt(6'd32), 32'h0000_0000);
        chk("fmt_63", model_fmt(6'd63), 32'h1F00_0000);

        // Phase 1: fixed sample 63, playing, always allowed.
        #1 check_zero_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        first_write = 0;
        first_data = 32'd0;
        for (int i = 1; i <= 3 * P_DIV; i++) begin
            step();
            if (write_audio_out && first_write == 0) begin
                first_write = i;
                first_data = left_out;
            end
        end
        chk("first_write_cycle", first_write, 32'd10);
        chk("first_write_data", first_data, 32'h1F00_0000);

        // Phase 2: mute with sample 0 -> zero words, address frozen.
        do_reset();
        fixed_val = 6'd0;
        enable = 1'b0;
        held_addr = ram_addr;
        for (int i = 0; i < 4 * P_DIV; i++) step();
        chk("mute_addr_hold", {12'd0, ram_addr}, {12'd0, held_addr});

        // Phase 3: overflow with audio blocked for six ticks.
        do_reset();
        use_fixed = 1'b0;
        enable = 1'b1;
        allowed = 1'b0;
        for (int i = 0; i < 6 * P_DIV + 2; i++) step();
        chk("overflow_dropped", {31'd0, dropped}, 32'd1);
        chk("overflow_addr", {12'd0, ram_addr}, 32'd4);
        allowed = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Phase 4: restart landing on the capture cycle.
        allowed = 1'b0;
        waited = 0;
        while (m_stage != 2 && waited < 4 * P_DIV) begin
            step();
            waited++;
        end
        chk("cap_reached", {31'd0, m_stage == 2}, 32'd1);
        restart = 1'b1;
        allowed = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_addr", {12'd0, ram_addr}, 32'd0);
        chk("restart_empty", {31'd0, write_audio_out}, 32'd0);
        chk("restart_dropped", {31'd0, dropped}, 32'd0);
        chk("restart_done", {31'd0, song_done}, 32'd0);

        // Phase 5: reset while a fetch is presenting its address.
        allowed = 1'b0;
        waited = 0;
        while (!(m_stage == 1 && m_fifo.size() > 0) && waited < 6 * P_DIV) begin
            step();
            waited++;
        end
        chk("req_reached", {31'd0, m_stage == 1}, 32'd1);
        do_reset();
        allowed = 1'b1;
        for (int i = 0; i < 2 * P_DIV; i++) step();

        // Phase 6: randomized traffic, restarts and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            allowed = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) < 20) allowed = 1'b0;
            restart = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/song_sample_player.md
SONG_SAMPLE_PLAYER -- requirements
Module: song_sample_player

Interface
REQ-001 SHALL have parameter DIV, default 1042, meaning the sample period in CLOCK_50 cycles (about 48 kHz).
REQ-002 SHALL have parameter LAST_ADDR, default 633867, meaning the final song RAM address before wrap.
REQ-003 SHALL have parameter SHIFT, default 24, meaning the left-shift applied to the centred sample.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the sample FIFO (power of 2).
REQ-005 CLOCK_50  in  1  sole clock; every flop is rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  1 = play from RAM; 0 = mute (push zero samples).
REQ-008 restart  in  1  single-cycle pulse: rewind to address 0 and flush.
REQ-009 ram_addr  out  20  song RAM read address.
REQ-010 ram_q  in  6  unsigned song RAM data, registered RAM with 1-cycle read latency.
REQ-011 audio_out_allowed  in  1  downstream audio controller can accept a sample.
REQ-012 write_audio_out  out  1  write strobe to the audio controller.
REQ-013 left_channel_audio_out  out  32  sample word, left channel.
REQ-014 right_channel_audio_out  out  32  sample word, right channel; always equal to the left channel.
REQ-015 song_done  out  1  one-cycle pulse on address wrap.
REQ-016 dropped  out  1  sticky flag: a sample tick was lost because the FIFO was full.

Function
REQ-017 Tick counter SHALL count 0..DIV-1 continuously; a tick is asserted in the cycle the count equals DIV-1, and the count then returns to 0.
REQ-018 Fetch FSM SHALL have the states IDLE, REQ and CAP.
  - IDLE -> REQ on a tick when the FIFO is not full.
  - REQ -> CAP unconditionally.
  - CAP -> IDLE unconditionally.
REQ-019 ram_addr SHALL equal the internal address register at all times.
REQ-020 In CAP, the block SHALL push exactly one sample into the FIFO.
  - enable=1: the pushed sample is formatted ram_q, and the address advances.
  - enable=0: the pushed sample is 32'd0, and the address holds.
REQ-021 Formatting SHALL be: value = (ram_q - 32) * 2^SHIFT as 32-bit two's complement.
  - ram_q=0 -> 0xE0000000; ram_q=32 -> 0; ram_q=63 -> 0x1F000000 (SHIFT=24).
REQ-022 Address advance SHALL be addr+1, except addr==LAST_ADDR -> 0 with song_done=1 for that one cycle.
REQ-023 A tick in IDLE with the FIFO full SHALL keep the FSM in IDLE, not advance the address, and set dropped.
REQ-024 A tick arriving while in REQ or CAP SHALL be ignored and SHALL NOT set dropped (impossible for DIV >= 3).
REQ-025 Output side SHALL be write_audio_out = FIFO-not-empty AND audio_out_allowed (combinational).
  - The data outputs equal the FIFO head while the FIFO is non-empty, and 0 while it is empty.
  - The FIFO pops on each cycle write_audio_out=1.
REQ-026 Simultaneous push and pop SHALL both take effect with occupancy unchanged; this is also legal when the FIFO is full, since the pop frees the slot.
REQ-027 Latency SHALL be: tick in cycle T -> REQ at T+1, CAP/push at the T+2 edge, earliest write_audio_out at T+3.
REQ-028 restart SHALL take priority over every other event in the same cycle; on the next edge it sets:
  - address = 0, FIFO empty, FSM = IDLE, dropped = 0;
  - any in-flight fetch aborted with no push;
  - the tick counter unaffected.
REQ-029 A restart arriving in the CAP cycle SHALL suppress that push, and song_done SHALL NOT pulse.
REQ-030 A change of enable SHALL take effect at the next CAP state; FIFO contents already queued are not altered.

Reset
REQ-031 While reset=1, the block SHALL hold the following values, applied asynchronously:
  - tick count 0, FSM IDLE, address 0, FIFO empty;
  - write_audio_out 0, data outputs 0, song_done 0, dropped 0.
REQ-032 The first tick after reset release SHALL occur DIV cycles after the first rising edge with reset=0.

Verification
REQ-033 Reset release with enable=1, audio_out_allowed=1, ram_q=63 -> write_audio_out pulses once every 1042 cycles, 3 cycles after each tick, data 0x1F000000 on both channels.
REQ-034 enable=0, ram_q=0 -> each write carries 0x00000000, and ram_addr stays constant.
REQ-035 LAST_ADDR=3, enable=1 -> ram_addr sequence 0,1,2,3,0; song_done is high for exactly 1 cycle at the 3->0 advance.
REQ-036 audio_out_allowed=0 for 6 ticks -> FIFO holds 4 entries, dropped=1 from tick 5, address advanced by 4 only; raising allowed -> 4 consecutive writes in order.
REQ-037 restart asserted in the CAP cycle with FIFO=2 entries -> no push, ram_addr=0 and FIFO empty next cycle, dropped=0, no song_done.
REQ-038 reset asserted mid-REQ -> all outputs 0 immediately without a clock edge, and FSM in IDLE after release.
